// File: rtl/ad7606_pkg.sv
// rtl/ad7606_pkg.sv - shared states and default timing for the AD7606 conversion sequencer
package ad7606_pkg;

  typedef enum logic [2:0] {
    RESET_AD,
    IDLE,
    CONV,
    WAIT_BH,
    WAIT_BL,
    READ,
    GAP
  } ad7606_state_t;

  localparam int RST_PULSE_CYC_DEF  = 5;
  localparam int CONVST_LOW_CYC_DEF = 2;
  localparam int BUSY_TIMEOUT_DEF   = 500;
  localparam int PERIOD_W_DEF       = 24;
  localparam int CNT_W_DEF          = 8;
  localparam int CH_NUM             = 8;

endpackage

// File: rtl/ad7606_period_tmr.sv
// rtl/ad7606_period_tmr.sv - conversion period down-counter; expired holds until the next load
module ad7606_period_tmr #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                expired
);

  logic [PERIOD_W-1:0] cnt;

  // Loaded with period-1 so expired is already high in the cycle before the period ends,
  // letting the sequencer drop convst exactly period cycles after the previous fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b1;
    end else if (load) begin
      cnt     <= (load_val == '0) ? '0 : load_val - PERIOD_W'(1);
      expired <= (load_val <= PERIOD_W'(1));
    end else if (cnt != '0) begin
      cnt     <= cnt - PERIOD_W'(1);
      expired <= (cnt == PERIOD_W'(1));
    end
  end

endmodule

// File: rtl/ad7606_conv_sched.sv
// rtl/ad7606_conv_sched.sv - AD7606 reset/CONVST/BUSY sequencer with per-conversion read requests
// Optional: define SAMPLE_TS_EN to add the sample_ts timestamp output.
module ad7606_conv_sched
  import ad7606_pkg::*;
#(
  parameter int RST_PULSE_CYC  = RST_PULSE_CYC_DEF,
  parameter int CONVST_LOW_CYC = CONVST_LOW_CYC_DEF,
  parameter int BUSY_TIMEOUT   = BUSY_TIMEOUT_DEF,
  parameter int PERIOD_W       = PERIOD_W_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic                ad_busy,
  input  logic                rd_done,
  output logic                ad_rst,
  output logic                convst,
  output logic                rd_req,
  output logic [CNT_W-1:0]    sample_idx,
  output logic                active,
  output logic                burst_done,
  output logic                timeout_err,
  output logic                overrun_err
`ifdef SAMPLE_TS_EN
  ,
  output logic [31:0]         sample_ts
`endif
);

  localparam int RST_W = $clog2(RST_PULSE_CYC + 1);
  localparam int CLW   = $clog2(CONVST_LOW_CYC + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYC - 1);
  localparam logic [CLW-1:0]   CL_LAST  = CLW'(CONVST_LOW_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  ad7606_state_t       state;
  logic [RST_W-1:0]    rst_cnt;
  logic [CLW-1:0]      conv_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PERIOD_W-1:0] period_q;
  logic [CNT_W-1:0]    burst_len_q;
  logic [CNT_W-1:0]    idx_next;
  logic                abort_pend;
  logic                last_conv;
  logic                start_ok;
  logic                gap_go;
  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_val;
  logic                tmr_expired;

  assign idx_next  = sample_idx + CNT_W'(1);
  assign last_conv = (burst_len_q != '0) && (idx_next == burst_len_q);
  // Every convst falling edge reloads the period timer in the same cycle.
  assign start_ok  = (state == IDLE) && start;
  assign gap_go    = (state == GAP) && !abort && tmr_expired;
  assign tmr_load  = start_ok || gap_go;
  assign tmr_val   = start_ok ? period : period_q;

  ad7606_period_tmr #(.PERIOD_W(PERIOD_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_AD;
      rst_cnt     <= '0;
      conv_cnt    <= '0;
      tmo_cnt     <= '0;
      period_q    <= '0;
      burst_len_q <= '0;
      abort_pend  <= 1'b0;
      ad_rst      <= 1'b1;
      convst      <= 1'b1;
      rd_req      <= 1'b0;
      sample_idx  <= '0;
      active      <= 1'b0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rd_req     <= 1'b0;
      burst_done <= 1'b0;
      // Period 0 means back-to-back, so an always-expired timer is not an overrun.
      if ((state == WAIT_BH || state == WAIT_BL || state == READ) &&
          tmr_expired && period_q != '0)
        overrun_err <= 1'b1;
      case (state)
        RESET_AD: begin
          if (rst_cnt == RST_LAST) begin
            ad_rst <= 1'b0;
            state  <= IDLE;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        IDLE: begin
          if (start) begin
            period_q    <= period;
            burst_len_q <= burst_len;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            sample_idx  <= '0;
            abort_pend  <= 1'b0;
            active      <= 1'b1;
            convst      <= 1'b0;
            conv_cnt    <= '0;
            state       <= CONV;
          end
        end
        CONV: begin
          if (abort) abort_pend <= 1'b1;
          if (conv_cnt == CL_LAST) begin
            convst  <= 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_BH;
          end else begin
            conv_cnt <= conv_cnt + CLW'(1);
          end
        end
        WAIT_BH: begin
          if (abort) abort_pend <= 1'b1;
          if (ad_busy) begin
            tmo_cnt <= '0;
            state   <= WAIT_BL;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            active      <= 1'b0;
            ad_rst      <= 1'b1;
            rst_cnt     <= '0;
            state       <= RESET_AD;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WAIT_BL: begin
          if (abort) abort_pend <= 1'b1;
          if (!ad_busy) begin
            if (abort_pend || abort) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              rd_req <= 1'b1;
              state  <= READ;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            active      <= 1'b0;
            ad_rst      <= 1'b1;
            rst_cnt     <= '0;
            state       <= RESET_AD;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        READ: begin
          if (abort) abort_pend <= 1'b1;
          if (rd_done) begin
            // Final conversion takes priority over a coincident abort.
            if (last_conv) begin
              burst_done <= 1'b1;
              active     <= 1'b0;
              state      <= IDLE;
            end else if (abort_pend || abort) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              sample_idx <= idx_next;
              state      <= GAP;
            end
          end
        end
        GAP: begin
          if (abort) begin
            active <= 1'b0;
            state  <= IDLE;
          end else if (tmr_expired) begin
            convst   <= 1'b0;
            conv_cnt <= '0;
            state    <= CONV;
          end
        end
        default: state <= RESET_AD;
      endcase
    end
  end

`ifdef SAMPLE_TS_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt    <= '0;
      sample_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (tmr_load) sample_ts <= ts_cnt;
    end
  end
`endif

endmodule
